// File: rtl/pkt_byte_sched.sv
// Round-robin byte scheduler feeding the shared 8-bit adder; SCHED_CHECK_EN adds a sum checker.
// Latency: first op byte one cycle after grant, res_o RES_LAT+1 after its op byte; no backpressure once granted.
module pkt_byte_sched #(
  parameter int NUM_REQ = 2,
  parameter int PKT_W   = 4096,
  parameter int LEN_W   = 10,
  parameter int RES_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_vld_i,
  input  logic [NUM_REQ*PKT_W-1:0]   req_data_i,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len_i,
  output logic [NUM_REQ-1:0]         req_rdy_o,
  output logic [7:0]                 op_a_o,
  output logic [7:0]                 op_b_o,
  output logic                       op_vld_o,
  input  logic [7:0]                 res_i,
  output logic [7:0]                 res_o,
  output logic                       res_vld_o,
  output logic [2:0]                 res_src_o,
  output logic                       res_last_o,
  output logic                       busy_o,
  output logic                       pkt_done_o,
  output logic [15:0]                pkt_cnt_o,
  output logic [15:0]                err_cnt_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam int NBYTES = PKT_W / 8;
`ifdef SCHED_CHECK_EN
  localparam int TAG_W = 13;
`else
  localparam int TAG_W = 5;
`endif

  state_t             state_q, state_d;
  logic [PKT_W-1:0]   shreg_q, shreg_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         src_q, src_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic               pkt_done;

  logic               gnt_found;
  logic [2:0]         gnt_idx;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [PKT_W-1:0]   gnt_data;
  logic [LEN_W-1:0]   gnt_len;

  // Search ptr+1 .. NUM_REQ-1 first, then wrap to 0 .. ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (state_q == IDLE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_found && req_vld_i[i] && (i > int'(ptr_q))) begin
          gnt_found = 1'b1;
          gnt_idx   = 3'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_found && req_vld_i[i] && (i <= int'(ptr_q))) begin
          gnt_found = 1'b1;
          gnt_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_vec  = '0;
    gnt_data = '0;
    gnt_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && (gnt_idx == 3'(i))) begin
        gnt_vec[i] = 1'b1;
        gnt_data   = req_data_i[i*PKT_W +: PKT_W];
        gnt_len    = req_len_i[i*LEN_W +: LEN_W];
      end
    end
  end

  assign req_rdy_o = gnt_vec;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    pkt_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          shreg_d = gnt_data;
          len_d   = (gnt_len == '0) ? LEN_W'(NBYTES) : gnt_len;
          src_d   = gnt_idx;
          ptr_d   = gnt_idx;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        shreg_d = shreg_q >> 8;
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      DRAIN: begin
        // The last result leaves the output register in the final drain cycle.
        if (cnt_q == LEN_W'(RES_LAT)) begin
          pkt_done  = 1'b1;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      src_q     <= '0;
      ptr_q     <= 3'(NUM_REQ - 1);
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      ptr_q     <= ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  logic op_vld;
  logic cur_last;
  assign op_vld     = (state_q == STREAM);
  assign cur_last   = op_vld && (cnt_q == len_q - LEN_W'(1));
  assign op_vld_o   = op_vld;
  assign op_a_o     = op_vld ? shreg_q[7:0] : 8'h00;
  assign op_b_o     = op_vld ? shreg_q[7:0] : 8'h00;
  assign busy_o     = (state_q != IDLE);
  assign pkt_done_o = pkt_done;
  assign pkt_cnt_o  = pkt_cnt_q;

  // Tag travels beside the adder so it lines up with res_i.
  logic [TAG_W-1:0] cur_tag;
  logic [TAG_W-1:0] al_tag;
`ifdef SCHED_CHECK_EN
  assign cur_tag = {op_vld, src_q, cur_last, shreg_q[6:0], 1'b0};
`else
  assign cur_tag = {op_vld, src_q, cur_last};
`endif

  generate
    if (RES_LAT == 0) begin : g_nodly
      assign al_tag = cur_tag;
    end else begin : g_dly
      logic [TAG_W-1:0] pipe_q [RES_LAT];
      logic [TAG_W-1:0] pipe_d [RES_LAT];
      always_comb begin
        pipe_d[0] = cur_tag;
        for (int i = 1; i < RES_LAT; i++) pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          for (int i = 0; i < RES_LAT; i++) pipe_q[i] <= '0;
        end else begin
          for (int i = 0; i < RES_LAT; i++) pipe_q[i] <= pipe_d[i];
        end
      end
      assign al_tag = pipe_q[RES_LAT-1];
    end
  endgenerate

  logic       al_vld, al_last;
  logic [2:0] al_src;
  logic [7:0] res_q, res_d;
  logic       res_vld_q, res_vld_d;
  logic [2:0] res_src_q, res_src_d;
  logic       res_last_q, res_last_d;

`ifdef SCHED_CHECK_EN
  logic [7:0]  al_exp;
  logic [7:0]  exp_q, exp_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  assign {al_vld, al_src, al_last, al_exp} = al_tag;
`else
  assign {al_vld, al_src, al_last} = al_tag;
`endif

  always_comb begin
    res_vld_d  = al_vld;
    res_d      = al_vld ? res_i : 8'h00;
    res_src_d  = al_vld ? al_src : 3'd0;
    res_last_d = al_vld && al_last;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      res_src_q  <= '0;
      res_last_q <= 1'b0;
    end else begin
      res_q      <= res_d;
      res_vld_q  <= res_vld_d;
      res_src_q  <= res_src_d;
      res_last_q <= res_last_d;
    end
  end

  assign res_o      = res_q;
  assign res_vld_o  = res_vld_q;
  assign res_src_o  = res_src_q;
  assign res_last_o = res_last_q;

`ifdef SCHED_CHECK_EN
  always_comb begin
    exp_d     = al_vld ? al_exp : 8'h00;
    err_cnt_d = err_cnt_q;
    if (res_vld_q && (res_q != exp_q) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exp_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      exp_q     <= exp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pkt_byte_sched.sv
// Scoreboard bench for pkt_byte_sched: directed packets, adder modelled with one-cycle latency.
module tb_pkt_byte_sched;
  localparam int NUM_REQ = 2;
  localparam int PKT_W   = 4096;
  localparam int LEN_W   = 10;
  localparam int RES_LAT = 1;

  logic                     clk_i = 1'b0;
  logic                     reset_i;
  logic [NUM_REQ-1:0]       req_vld_i;
  logic [NUM_REQ*PKT_W-1:0] req_data_i;
  logic [NUM_REQ*LEN_W-1:0] req_len_i;
  logic [NUM_REQ-1:0]       req_rdy_o;
  logic [7:0]               op_a_o, op_b_o;
  logic                     op_vld_o;
  logic [7:0]               res_i = 8'h00;
  logic [7:0]               res_o;
  logic                     res_vld_o;
  logic [2:0]               res_src_o;
  logic                     res_last_o;
  logic                     busy_o;
  logic                     pkt_done_o;
  logic [15:0]              pkt_cnt_o;
  logic [15:0]              err_cnt_o;

  int checks = 0;
  int errors = 0;
  int pkt_model = 0;
  logic corrupt_en = 1'b0;

  logic [7:0]  exp_op  [$];
  logic [11:0] exp_res [$];
  logic [7:0]  e_op;
  logic [11:0] e_res;

  pkt_byte_sched #(
    .NUM_REQ(NUM_REQ), .PKT_W(PKT_W), .LEN_W(LEN_W), .RES_LAT(RES_LAT)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_vld_i(req_vld_i), .req_data_i(req_data_i), .req_len_i(req_len_i),
    .req_rdy_o(req_rdy_o),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .op_vld_o(op_vld_o),
    .res_i(res_i),
    .res_o(res_o), .res_vld_o(res_vld_o), .res_src_o(res_src_o), .res_last_o(res_last_o),
    .busy_o(busy_o), .pkt_done_o(pkt_done_o), .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Adder model, one cycle of latency; can inject a bad sum on byte 0xC3.
  always @(posedge clk_i)
    res_i <= (corrupt_en && op_a_o == 8'hC3) ? 8'hFF : 8'(op_a_o + op_b_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (op_vld_o) begin
      if (exp_op.size() == 0) begin
        chk("op_unexpected", {24'h0, op_a_o}, 32'hFFFF_FFFF);
      end else begin
        e_op = exp_op.pop_front();
        chk("op_a", {24'h0, op_a_o}, {24'h0, e_op});
        chk("op_b", {24'h0, op_b_o}, {24'h0, e_op});
      end
    end
    if (res_vld_o) begin
      if (exp_res.size() == 0) begin
        chk("res_unexpected", {24'h0, res_o}, 32'hFFFF_FFFF);
      end else begin
        e_res = exp_res.pop_front();
        chk("res_o", {24'h0, res_o}, {24'h0, e_res[7:0]});
        chk("res_last", {31'h0, res_last_o}, {31'h0, e_res[8]});
        chk("res_src", {29'h0, res_src_o}, {29'h0, e_res[11:9]});
      end
    end
  end

  task automatic set_req(input int k, input logic [PKT_W-1:0] d, input int len);
    req_data_i[k*PKT_W +: PKT_W] = d;
    req_len_i[k*LEN_W +: LEN_W]  = LEN_W'(len);
    req_vld_i[k]                 = 1'b1;
  endtask

  task automatic push_pkt(input int k, input logic [PKT_W-1:0] d, input int n, input int bad);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      logic [7:0] r;
      b = d[i*8 +: 8];
      r = (i == bad) ? 8'hFF : 8'(b + b);
      exp_op.push_back(b);
      exp_res.push_back({3'(k), (i == n - 1), r});
    end
  endtask

  // Returns at posedge+1 of the first STREAM cycle.
  task automatic wait_grant(input int k, input string name);
    int n;
    n = 0;
    @(negedge clk_i);
    while (req_rdy_o == '0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_rdy"}, 32'(req_rdy_o), 32'(1 << k));
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_pkt_end(input int n_exp, input string name);
    int ops, tail, dones, guard;
    logic done_last;
    ops = 0; tail = 0; dones = 0; guard = 0; done_last = 1'b0;
    while (op_vld_o && guard < 2000) begin
      ops++;
      if (pkt_done_o) dones++;
      @(posedge clk_i); #1; guard++;
    end
    while (busy_o && guard < 2000) begin
      tail++;
      done_last = pkt_done_o;
      if (pkt_done_o) dones++;
      @(posedge clk_i); #1; guard++;
    end
    chk({name, "_ops"}, 32'(ops), 32'(n_exp));
    chk({name, "_drain"}, 32'(tail), 32'(RES_LAT + 1));
    chk({name, "_dones"}, 32'(dones), 32'd1);
    chk({name, "_done_last"}, {31'h0, done_last}, 32'd1);
    pkt_model++;
    chk({name, "_pkt_cnt"}, {16'h0, pkt_cnt_o}, 32'(pkt_model));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PKT_W-1:0] d;
    logic [PKT_W-1:0] d0;
    logic [PKT_W-1:0] d1;
    reset_i    = 1'b1;
    req_vld_i  = '0;
    req_data_i = '0;
    req_len_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    chk("rst_op_vld", {31'h0, op_vld_o}, 0);
    chk("rst_op_a", {24'h0, op_a_o}, 0);
    chk("rst_res_vld", {31'h0, res_vld_o}, 0);
    chk("rst_res_o", {24'h0, res_o}, 0);
    chk("rst_busy", {31'h0, busy_o}, 0);
    chk("rst_done", {31'h0, pkt_done_o}, 0);
    chk("rst_pkt_cnt", {16'h0, pkt_cnt_o}, 0);
    chk("rst_err_cnt", {16'h0, err_cnt_o}, 0);
    chk("rst_rdy", 32'(req_rdy_o), 0);

    // Single packet, trailing byte EE must not be sent.
    d = '0;
    d[7:0] = 8'h01; d[15:8] = 8'h02; d[23:16] = 8'h03; d[31:24] = 8'h80; d[39:32] = 8'hEE;
    set_req(0, d, 4);
    exp_op.push_back(8'h01); exp_op.push_back(8'h02);
    exp_op.push_back(8'h03); exp_op.push_back(8'h80);
    exp_res.push_back(12'h002); exp_res.push_back(12'h004);
    exp_res.push_back(12'h006); exp_res.push_back(12'h100);
    wait_grant(0, "t1");
    req_vld_i = '0;
    wait_pkt_end(4, "t1");

    // Full-length packet from the only valid requester.
    for (int i = 0; i < PKT_W / 8; i++) d[i*8 +: 8] = 8'(i * 7 + 3);
    set_req(1, d, 0);
    push_pkt(1, d, 512, -1);
    wait_grant(1, "t2");
    req_vld_i = '0;
    wait_pkt_end(512, "t2");

    // Both requesters valid: grants must alternate 0,1,0,1.
    d0 = '0; d0[7:0] = 8'h11; d0[15:8] = 8'h22;
    d1 = '0; d1[7:0] = 8'h33; d1[15:8] = 8'hC4;
    set_req(0, d0, 2);
    set_req(1, d1, 2);
    for (int p = 0; p < 4; p++) begin
      push_pkt(p % 2, (p % 2 == 0) ? d0 : d1, 2, -1);
      wait_grant(p % 2, "t3");
      if (p >= 2) req_vld_i[p % 2] = 1'b0;
      wait_pkt_end(2, "t3");
    end

    // Reset while byte 100 of 512 is on the operand port.
    for (int i = 0; i < PKT_W / 8; i++) d[i*8 +: 8] = 8'(i + 9);
    set_req(0, d, 0);
    push_pkt(0, d, 512, -1);
    wait_grant(0, "t4");
    req_vld_i = '0;
    repeat (99) begin
      @(posedge clk_i); #1;
    end
    chk("t4_byte100", {24'h0, op_a_o}, 32'(8'(99 + 9)));
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    chk("t4_op_vld", {31'h0, op_vld_o}, 0);
    chk("t4_op_a", {24'h0, op_a_o}, 0);
    chk("t4_res_vld", {31'h0, res_vld_o}, 0);
    chk("t4_res_o", {24'h0, res_o}, 0);
    chk("t4_busy", {31'h0, busy_o}, 0);
    chk("t4_done", {31'h0, pkt_done_o}, 0);
    chk("t4_pkt_cnt", {16'h0, pkt_cnt_o}, 0);
    exp_op.delete();
    exp_res.delete();
    pkt_model = 0;
    reset_i = 1'b0;
    d0 = '0; d0[7:0] = 8'h5A; d0[15:8] = 8'hA5;
    set_req(0, d0, 2);
    set_req(1, d1, 2);
    push_pkt(0, d0, 2, -1);
    wait_grant(0, "t4_after");
    req_vld_i = '0;
    wait_pkt_end(2, "t4_after");

    // Corrupted sum on byte 3 of an 8-byte packet.
    d = '0;
    d[7:0] = 8'h10; d[15:8] = 8'h11; d[23:16] = 8'h12; d[31:24] = 8'hC3;
    d[39:32] = 8'h14; d[47:40] = 8'h15; d[55:48] = 8'h16; d[63:56] = 8'h17;
    corrupt_en = 1'b1;
    set_req(1, d, 8);
    push_pkt(1, d, 8, 3);
    wait_grant(1, "t5");
    req_vld_i = '0;
    wait_pkt_end(8, "t5");
    corrupt_en = 1'b0;
`ifdef SCHED_CHECK_EN
    chk("t5_err_cnt", {16'h0, err_cnt_o}, 1);
`else
    chk("t5_err_cnt", {16'h0, err_cnt_o}, 0);
`endif

    repeat (5) @(posedge clk_i);
    #1;
    chk("end_op_queue", 32'(exp_op.size()), 0);
    chk("end_res_queue", 32'(exp_res.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
